// File: rtl/panic_dma_rx_ring_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | panic_dma_rx_ring_pkg                                              |
// | Shared defaults, FSM state encoding and helpers for the rx ring.   |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
package panic_dma_rx_ring_pkg;

  localparam int PANIC_DMA_RING_AXIS_DATA_WIDTH = 512;
  localparam int PANIC_DMA_RING_AXIS_KEEP_WIDTH = 64;
  localparam int PANIC_DMA_RING_ADDR_WIDTH      = 64;
  localparam int PANIC_DMA_RING_LEN_WIDTH       = 16;
  localparam int PANIC_DMA_RING_TAG_WIDTH       = 8;
  localparam int PANIC_DMA_RING_RING_LOG        = 6;
  localparam int PANIC_DMA_RING_SLOT_LOG        = 11;

  // Packet-path FSM: wait for packet, issue descriptor, stream, discard overflow
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DESC = 2'd1,
    ST_DATA = 2'd2,
    ST_DROP = 2'd3
  } ring_state_e;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/panic_dma_rx_ring_keep_popcount.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | panic_dma_rx_ring_keep_popcount                                    |
// | Counts set tkeep bits, i.e. valid bytes in one stream beat.        |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module panic_dma_rx_ring_keep_popcount #(
  parameter int KEEP_WIDTH = 64,
  parameter int CNT_WIDTH  = $clog2(KEEP_WIDTH) + 1
) (
  input  logic [KEEP_WIDTH-1:0] keep_i,
  output logic [CNT_WIDTH-1:0]  cnt_o
);

  // Plain adder chain; synthesis rebalances it into a tree
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      cnt_o = cnt_o + CNT_WIDTH'(keep_i[i]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/panic_dma_rx_ring.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | panic_dma_rx_ring                                                  |
// | Maps rx packets onto host ring slots: one DMA write descriptor per |
// | packet, payload passthrough with slot-size truncation, in-order    |
// | completions from DMA write status.                                 |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module panic_dma_rx_ring
  import panic_dma_rx_ring_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH = PANIC_DMA_RING_AXIS_DATA_WIDTH,
  parameter int AXIS_KEEP_WIDTH = PANIC_DMA_RING_AXIS_KEEP_WIDTH,
  parameter int DMA_ADDR_WIDTH  = PANIC_DMA_RING_ADDR_WIDTH,
  parameter int LEN_WIDTH       = PANIC_DMA_RING_LEN_WIDTH,
  parameter int TAG_WIDTH       = PANIC_DMA_RING_TAG_WIDTH,
  parameter int RING_LOG        = PANIC_DMA_RING_RING_LOG,
  parameter int SLOT_LOG        = PANIC_DMA_RING_SLOT_LOG
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [AXIS_DATA_WIDTH-1:0] s_rx_axis_tdata_i,
  input  logic [AXIS_KEEP_WIDTH-1:0] s_rx_axis_tkeep_i,
  input  logic                       s_rx_axis_tvalid_i,
  input  logic                       s_rx_axis_tlast_i,
  output logic                       s_rx_axis_tready_o,
  input  logic [DMA_ADDR_WIDTH-1:0]  cfg_ring_base_i,
  input  logic [RING_LOG:0]          host_tail_ptr_i,
  output logic [DMA_ADDR_WIDTH-1:0]  m_wr_desc_addr_o,
  output logic [LEN_WIDTH-1:0]       m_wr_desc_len_o,
  output logic [TAG_WIDTH-1:0]       m_wr_desc_tag_o,
  output logic                       m_wr_desc_valid_o,
  input  logic                       m_wr_desc_ready_i,
  output logic [AXIS_DATA_WIDTH-1:0] m_wr_data_tdata_o,
  output logic [AXIS_KEEP_WIDTH-1:0] m_wr_data_tkeep_o,
  output logic                       m_wr_data_tvalid_o,
  output logic                       m_wr_data_tlast_o,
  input  logic                       m_wr_data_tready_i,
  input  logic [TAG_WIDTH-1:0]       s_wr_status_tag_i,
  input  logic [LEN_WIDTH-1:0]       s_wr_status_len_i,
  input  logic                       s_wr_status_valid_i,
  output logic                       cpl_valid_o,
  output logic [RING_LOG-1:0]        cpl_slot_o,
  output logic [LEN_WIDTH-1:0]       cpl_len_o,
  output logic [RING_LOG:0]          prod_ptr_o,
  output logic [RING_LOG:0]          cons_ptr_o,
  output logic [31:0]                trunc_count_o
);

  localparam int KCNT_WIDTH = $clog2(AXIS_KEEP_WIDTH) + 1;
  localparam int PTR_WIDTH  = RING_LOG + 1;
  localparam int BCNT_WIDTH = SLOT_LOG + 1;
  localparam logic [BCNT_WIDTH-1:0] SLOT_BYTES = BCNT_WIDTH'(1) << SLOT_LOG;
  localparam logic [LEN_WIDTH-1:0]  SLOT_LEN   = LEN_WIDTH'(1) << SLOT_LOG;

  ring_state_e               state_q, state_d;
  logic [PTR_WIDTH-1:0]      prod_ptr_q, cons_ptr_q;
  logic [BCNT_WIDTH-1:0]     byte_cnt_q;
  logic [DMA_ADDR_WIDTH-1:0] desc_addr_q;
  logic [TAG_WIDTH-1:0]      desc_tag_q;
  logic [LEN_WIDTH-1:0]      desc_len_q;
  logic [31:0]               trunc_q;
  logic                      cpl_valid_q;
  logic [RING_LOG-1:0]       cpl_slot_q;
  logic [LEN_WIDTH-1:0]      cpl_len_q;

  logic [KCNT_WIDTH-1:0]     w_keep_cnt;
  logic [BCNT_WIDTH-1:0]     w_byte_sum;
  logic [RING_LOG-1:0]       w_prod_idx;
  logic                      w_slot_free;
  logic                      w_issue;
  logic                      w_desc_fire;
  logic                      w_data_beat;
  logic                      w_fill;

  panic_dma_rx_ring_keep_popcount #(
    .KEEP_WIDTH (AXIS_KEEP_WIDTH),
    .CNT_WIDTH  (KCNT_WIDTH)
  ) u_keep_popcount (
    .keep_i (s_rx_axis_tkeep_i),
    .cnt_o  (w_keep_cnt)
  );

  // Equal pointers (including wrap bit) mean the host has granted no free slot
  assign w_slot_free = (prod_ptr_q != host_tail_ptr_i);
  assign w_prod_idx  = RING_LOG'(prod_ptr_q);
  assign w_issue     = (state_q == ST_IDLE) && s_rx_axis_tvalid_i && w_slot_free;
  assign w_desc_fire = (state_q == ST_DESC) && m_wr_desc_ready_i;
  assign w_data_beat = (state_q == ST_DATA) && s_rx_axis_tvalid_i && m_wr_data_tready_i;
  assign w_byte_sum  = byte_cnt_q + BCNT_WIDTH'(w_keep_cnt);
  // Slot is full once this beat lands; a later s tlast is then beyond the slot
  assign w_fill      = (w_byte_sum >= SLOT_BYTES);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state: a tlast beat that exactly fills the slot ends normally
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (w_issue) state_d = ST_DESC;
      ST_DESC: if (m_wr_desc_ready_i) state_d = ST_DATA;
      ST_DATA: begin
        if (w_data_beat) begin
          if (s_rx_axis_tlast_i) state_d = ST_IDLE;
          else if (w_fill)       state_d = ST_DROP;
        end
      end
      ST_DROP: if (s_rx_axis_tvalid_i && s_rx_axis_tlast_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: zero-latency payload passthrough in DATA, sink-everything in DROP
  always_comb begin
    s_rx_axis_tready_o = 1'b0;
    m_wr_data_tvalid_o = 1'b0;
    m_wr_data_tlast_o  = 1'b0;
    m_wr_data_tdata_o  = '0;
    m_wr_data_tkeep_o  = '0;
    case (state_q)
      ST_DATA: begin
        s_rx_axis_tready_o = m_wr_data_tready_i;
        m_wr_data_tvalid_o = s_rx_axis_tvalid_i;
        m_wr_data_tdata_o  = s_rx_axis_tdata_i;
        m_wr_data_tkeep_o  = s_rx_axis_tkeep_i;
        m_wr_data_tlast_o  = s_rx_axis_tlast_i | w_fill;
      end
      ST_DROP: s_rx_axis_tready_o = 1'b1;
      default: ;
    endcase
  end

  // Descriptor fields latched at issue; producer advances on descriptor handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      desc_addr_q <= '0;
      desc_tag_q  <= '0;
      desc_len_q  <= '0;
      prod_ptr_q  <= '0;
    end else begin
      if (w_issue) begin
        desc_addr_q <= cfg_ring_base_i + (DMA_ADDR_WIDTH'(w_prod_idx) << SLOT_LOG);
        desc_tag_q  <= TAG_WIDTH'(w_prod_idx);
        desc_len_q  <= SLOT_LEN;
      end
      if (w_desc_fire) prod_ptr_q <= prod_ptr_q + PTR_WIDTH'(1);
    end
  end

  // Byte accounting within the current slot and truncated-packet counter
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt_q <= '0;
      trunc_q    <= '0;
    end else begin
      if (w_desc_fire)      byte_cnt_q <= '0;
      else if (w_data_beat) byte_cnt_q <= w_byte_sum;
      if ((state_q == ST_DROP) && s_rx_axis_tvalid_i && s_rx_axis_tlast_i)
        trunc_q <= sat_inc32(trunc_q);
    end
  end

  // Completion pulse one cycle after each write status; consumer follows statuses
  always_ff @(posedge clk) begin
    if (rst) begin
      cpl_valid_q <= 1'b0;
      cpl_slot_q  <= '0;
      cpl_len_q   <= '0;
      cons_ptr_q  <= '0;
    end else begin
      cpl_valid_q <= s_wr_status_valid_i;
      if (s_wr_status_valid_i) begin
        cpl_slot_q <= RING_LOG'(s_wr_status_tag_i);
        cpl_len_q  <= s_wr_status_len_i;
        cons_ptr_q <= cons_ptr_q + PTR_WIDTH'(1);
      end
    end
  end

  assign m_wr_desc_valid_o = (state_q == ST_DESC);
  assign m_wr_desc_addr_o  = desc_addr_q;
  assign m_wr_desc_len_o   = desc_len_q;
  assign m_wr_desc_tag_o   = desc_tag_q;
  assign cpl_valid_o       = cpl_valid_q;
  assign cpl_slot_o        = cpl_slot_q;
  assign cpl_len_o         = cpl_len_q;
  assign prod_ptr_o        = prod_ptr_q;
  assign cons_ptr_o        = cons_ptr_q;
  assign trunc_count_o     = trunc_q;

endmodule
`default_nettype wire

// File: tb/tb_panic_dma_rx_ring.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_panic_dma_rx_ring                                               |
// | Directed + randomized bench with a packet-level reference model.   |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module tb_panic_dma_rx_ring;

  logic         clk = 1'b0;
  logic         rst;
  logic [511:0] s_tdata;
  logic [63:0]  s_tkeep;
  logic         s_tvalid, s_tlast, s_tready;
  logic [63:0]  cfg_base;
  logic [6:0]   host_tail;
  logic [63:0]  desc_addr;
  logic [15:0]  desc_len;
  logic [7:0]   desc_tag;
  logic         desc_valid, desc_ready;
  logic [511:0] m_tdata;
  logic [63:0]  m_tkeep;
  logic         m_tvalid, m_tlast, m_tready;
  logic [7:0]   st_tag;
  logic [15:0]  st_len;
  logic         st_valid;
  logic         cpl_valid;
  logic [5:0]   cpl_slot;
  logic [15:0]  cpl_len;
  logic [6:0]   prod_ptr, cons_ptr;
  logic [31:0]  trunc_count;

  int total = 0;
  int bad   = 0;

  // Reference model state: packets issued, completions, truncations
  logic [6:0] exp_prod;
  logic [6:0] exp_cons;
  int         exp_trunc;

  always #5 clk = ~clk;

  panic_dma_rx_ring dut (
    .clk                (clk),
    .rst                (rst),
    .s_rx_axis_tdata_i  (s_tdata),
    .s_rx_axis_tkeep_i  (s_tkeep),
    .s_rx_axis_tvalid_i (s_tvalid),
    .s_rx_axis_tlast_i  (s_tlast),
    .s_rx_axis_tready_o (s_tready),
    .cfg_ring_base_i    (cfg_base),
    .host_tail_ptr_i    (host_tail),
    .m_wr_desc_addr_o   (desc_addr),
    .m_wr_desc_len_o    (desc_len),
    .m_wr_desc_tag_o    (desc_tag),
    .m_wr_desc_valid_o  (desc_valid),
    .m_wr_desc_ready_i  (desc_ready),
    .m_wr_data_tdata_o  (m_tdata),
    .m_wr_data_tkeep_o  (m_tkeep),
    .m_wr_data_tvalid_o (m_tvalid),
    .m_wr_data_tlast_o  (m_tlast),
    .m_wr_data_tready_i (m_tready),
    .s_wr_status_tag_i  (st_tag),
    .s_wr_status_len_i  (st_len),
    .s_wr_status_valid_i(st_valid),
    .cpl_valid_o        (cpl_valid),
    .cpl_slot_o         (cpl_slot),
    .cpl_len_o          (cpl_len),
    .prod_ptr_o         (prod_ptr),
    .cons_ptr_o         (cons_ptr),
    .trunc_count_o      (trunc_count)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Send one packet of len bytes (64 B per beat, last beat partial keep).
  // Model: slot = packet number mod 64, at most 32 beats reach the DMA engine,
  // the 32nd carries tlast when the packet is longer than the slot.
  // abort_after >= 0 returns once that many source beats have been accepted.
  task automatic run_pkt(input int len, input bit bp, input int abort_after, input bit inject_status);
    logic [511:0] beat_d [$];
    logic [63:0]  beat_k [$];
    logic [511:0] d;
    logic [63:0]  exp_addr;
    int nbeats, nfwd, src_i, fwd_i, ndesc, cyc, pend;
    bit trunc;
    nbeats = (len + 63) / 64;
    for (int i = 0; i < nbeats; i++) begin
      for (int j = 0; j < 16; j++) d[j*32 +: 32] = $urandom;
      beat_d.push_back(d);
      if (i == nbeats - 1 && (len % 64) != 0) beat_k.push_back((64'd1 << (len % 64)) - 64'd1);
      else                                    beat_k.push_back('1);
    end
    nfwd     = (nbeats > 32) ? 32 : nbeats;
    trunc    = (len > 2048);
    exp_addr = cfg_base + (64'(exp_prod[5:0]) * 64'd2048);
    src_i = 0; fwd_i = 0; ndesc = 0; cyc = 0; pend = 0;
    while (src_i < nbeats && !(abort_after >= 0 && src_i >= abort_after) && cyc < 4000) begin
      s_tvalid   = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_tdata    = beat_d[src_i];
      s_tkeep    = beat_k[src_i];
      s_tlast    = (src_i == nbeats - 1);
      desc_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      m_tready   = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      if (pend == 2) begin
        chk("cpl_valid", cpl_valid, 1);
        chk("cpl_slot", cpl_slot, 2);
        chk("cpl_len", cpl_len, 300);
        chk("cons_ptr_cpl", cons_ptr, exp_cons);
        chk("prod_ptr_cpl", prod_ptr, exp_prod + 7'd1);
        pend = 1;
      end else if (pend == 1) begin
        chk("cpl_pulse", cpl_valid, 0);
        pend = 0;
      end
      if (desc_valid && desc_ready) begin
        ndesc++;
        chk("desc_addr", desc_addr, exp_addr);
        chk("desc_tag", desc_tag, exp_prod[5:0]);
        chk("desc_len", desc_len, 2048);
        if (inject_status) begin
          st_tag = 8'd2; st_len = 16'd300; st_valid = 1'b1;
          exp_cons = exp_cons + 7'd1;
          pend = 2;
        end
      end
      if (m_tvalid && m_tready) begin
        if (fwd_i >= nfwd) chk("fwd_extra", fwd_i, nfwd - 1);
        else begin
          chk("wr_tdata", m_tdata, beat_d[fwd_i]);
          chk("wr_tkeep", m_tkeep, beat_k[fwd_i]);
          chk("wr_tlast", m_tlast, (fwd_i == nfwd - 1));
        end
        fwd_i++;
      end
      if (s_tvalid && s_tready) begin
        if (ndesc == 0) chk("early_accept", ndesc, 1);
        src_i++;
      end
      @(posedge clk); #1;
      st_valid = 1'b0;
      cyc++;
    end
    if (cyc >= 4000) chk("pkt_timeout", cyc, 0);
    if (abort_after >= 0) return;
    s_tvalid = 1'b0;
    exp_prod  = exp_prod + 7'd1;
    exp_trunc = exp_trunc + int'(trunc);
    chk("desc_count", ndesc, 1);
    chk("fwd_count", fwd_i, nfwd);
    chk("prod_ptr", prod_ptr, exp_prod);
    chk("trunc_count", trunc_count, exp_trunc);
  endtask

  initial begin
    rst = 1'b1;
    s_tdata = '0; s_tkeep = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
    cfg_base = 64'h0000_0001_2340_0000;
    host_tail = 7'd4;
    desc_ready = 1'b0; m_tready = 1'b0;
    st_tag = '0; st_len = '0; st_valid = 1'b0;
    exp_prod = '0; exp_cons = '0; exp_trunc = 0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_prod", prod_ptr, 0);
    chk("rst_cons", cons_ptr, 0);
    chk("rst_trunc", trunc_count, 0);
    chk("rst_desc_valid", desc_valid, 0);
    chk("rst_tready", s_tready, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_cpl_valid", cpl_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Four credits: four 128 B packets, then the fifth stalls until tail moves
    for (int p = 0; p < 4; p++) run_pkt(128, 1'b0, -1, 1'b0);
    s_tvalid = 1'b1; s_tkeep = '1; s_tlast = 1'b0; desc_ready = 1'b1; m_tready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("stall_tready", s_tready, 0);
      chk("stall_desc_valid", desc_valid, 0);
      @(posedge clk); #1;
    end
    host_tail = 7'd5;
    run_pkt(128, 1'b0, -1, 1'b0);

    // Exactly slot-sized packet, then an oversized one that gets truncated
    host_tail = exp_prod + 7'd64;
    run_pkt(2048, 1'b0, -1, 1'b0);
    host_tail = exp_prod + 7'd64;
    run_pkt(3000, 1'b0, -1, 1'b0);

    // Write status coincident with the descriptor handshake
    host_tail = exp_prod + 7'd64;
    run_pkt(200, 1'b0, -1, 1'b1);

    // Random lengths under random backpressure on every interface
    for (int p = 0; p < 10; p++) begin
      host_tail = exp_prod + 7'd64;
      run_pkt($urandom_range(1, 3000), 1'b1, -1, 1'b0);
    end

    // Tail advanced one slot per packet; producer wraps and reuses tag 0
    for (int p = 0; p < 70; p++) begin
      host_tail = exp_prod + 7'd1;
      run_pkt($urandom_range(1, 256), 1'b0, -1, 1'b0);
    end

    // Reset in the middle of a packet's payload
    host_tail = exp_prod + 7'd64;
    run_pkt(1000, 1'b0, 5, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_prod", prod_ptr, 0);
    chk("mid_rst_cons", cons_ptr, 0);
    chk("mid_rst_trunc", trunc_count, 0);
    chk("mid_rst_m_tvalid", m_tvalid, 0);
    chk("mid_rst_m_tlast", m_tlast, 0);
    chk("mid_rst_desc_valid", desc_valid, 0);
    chk("mid_rst_tready", s_tready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    s_tvalid = 1'b0;
    exp_prod = '0; exp_cons = '0; exp_trunc = 0;

    // Recovery after reset
    host_tail = exp_prod + 7'd64;
    run_pkt(300, 1'b1, -1, 1'b0);
    chk("final_cons", cons_ptr, exp_cons);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
